// File: rtl/cpu_hatch_rom.sv
// cpu_hatch_rom: responder side of the CPU instruction hatch.
// Serves a 48-bit instruction per word address combinationally, owns the program
// store, and runs a byte-serial loader that holds the CPU in reset until a load
// has finished plus a short release delay.
// Ports:
//   clk, rst_b          clock, asynchronous active-low reset
//   hatch_address       instruction word address from fetch
//   hatch_instruction   instruction at hatch_address (FILL_WORD outside the store)
//   load_start          pulse: restart program load at word 0
//   load_valid/_data    program byte stream, MSB-first within each word
//   load_last           marks the final byte of the program
//   load_ready          loader accepts a byte this cycle
//   load_error          sticky: program exceeded store depth
//   word_count          words written by the last/current load
//   cpu_rst_b           active-low reset to the CPU
module cpu_hatch_rom #(
   parameter int unsigned ADDR_W         = 10,
   parameter logic [47:0] FILL_WORD      = 48'h0,
   parameter int unsigned RELEASE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [31:0]       hatch_address,
   output logic [47:0]       hatch_instruction,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [7:0]        load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_error,
   output logic [ADDR_W:0]   word_count,
   output logic              cpu_rst_b
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned REL_W = $clog2(RELEASE_CYCLES) + 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [1:0] ST_RUN     = 2'd3;

   logic [47:0]      mem_q [DEPTH];

   logic [1:0]       state_q, state_d;
   logic [2:0]       byte_idx_q, byte_idx_d;
   logic [47:0]      asm_q, asm_d;
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic             err_q, err_d;
   logic [REL_W-1:0] rel_q, rel_d;
   logic             load_ready_q, cpu_rst_b_q;
   logic             we_c;
   logic [47:0]      word_c;

   // Combinational read; out-of-range word addresses return the fill pattern.
   always_comb begin
      if (hatch_address[31:ADDR_W] == '0) begin
         hatch_instruction = mem_q[hatch_address[ADDR_W-1:0]];
      end else begin
         hatch_instruction = FILL_WORD;
      end
   end

   // Assembly register with the incoming byte dropped into its slot; unfilled
   // low bytes stay zero, so a short last word is left-justified.
   always_comb begin
      word_c = asm_q;
      case (byte_idx_q)
         3'd0:    word_c[47:40] = load_data;
         3'd1:    word_c[39:32] = load_data;
         3'd2:    word_c[31:24] = load_data;
         3'd3:    word_c[23:16] = load_data;
         3'd4:    word_c[15:8]  = load_data;
         3'd5:    word_c[7:0]   = load_data;
         default: word_c        = asm_q;
      endcase
   end

   // Next-state logic for loader FSM and its datapath.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      wr_ptr_d   = wr_ptr_q;
      err_d      = err_q;
      rel_d      = rel_q;
      we_c       = 1'b0;

      if (load_start) begin
         // Restart wins over everything; a byte on this cycle is discarded.
         state_d    = ST_LOAD;
         byte_idx_d = 3'd0;
         asm_d      = 48'h0;
         wr_ptr_d   = '0;
         err_d      = 1'b0;
         rel_d      = '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (load_valid && load_ready_q) begin
                  if (byte_idx_q == 3'd5 || load_last) begin
                     asm_d      = 48'h0;
                     byte_idx_d = 3'd0;
                     // Store full: drop the word but keep draining the source.
                     if (wr_ptr_q == CNT_W'(DEPTH)) begin
                        err_d = 1'b1;
                     end else begin
                        we_c     = 1'b1;
                        wr_ptr_d = wr_ptr_q + CNT_W'(1);
                     end
                  end else begin
                     asm_d      = word_c;
                     byte_idx_d = byte_idx_q + 3'd1;
                  end
                  if (load_last) begin
                     state_d = ST_RELEASE;
                     rel_d   = '0;
                  end
               end
            end
            ST_RELEASE: begin
               if (rel_q == REL_W'(RELEASE_CYCLES - 1)) begin
                  state_d = ST_RUN;
               end else begin
                  rel_d = rel_q + REL_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q      <= ST_IDLE;
         byte_idx_q   <= 3'd0;
         asm_q        <= 48'h0;
         wr_ptr_q     <= '0;
         err_q        <= 1'b0;
         rel_q        <= '0;
         load_ready_q <= 1'b0;
         cpu_rst_b_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         asm_q        <= asm_d;
         wr_ptr_q     <= wr_ptr_d;
         err_q        <= err_d;
         rel_q        <= rel_d;
         load_ready_q <= (state_d == ST_LOAD);
         cpu_rst_b_q  <= (state_d == ST_RUN);
      end
   end

   // Program store; contents survive reset. we_c is only set in LOAD, so an
   // asserted reset can never commit a partial word.
   always_ff @(posedge clk) begin
      if (we_c) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= word_c;
      end
   end

   assign load_ready = load_ready_q;
   assign load_error = err_q;
   assign word_count = wr_ptr_q;
   assign cpu_rst_b  = cpu_rst_b_q;

endmodule
